ysyx_22050612_lsu: RTL

Multi-cycle load/store unit placed directly downstream of the execute stage. It takes one memory micro-op per transaction: the effective address from the EXU ALU, the store data from rs2, the access kind and rd. It then:
- runs a ready/valid request/response exchange on an 8-byte-wide data memory port;
- lane-aligns and sign/zero-extends load data;
- hands the writeback value to the WBU over a ready/valid interface.

Misaligned accesses are detected and reported, never split.

---
 rtl/ysyx_22050612_lsu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one memory op per transaction over a ready/valid
// 8-byte data port, with lane alignment, load extension and a ready/valid writeback.
module ysyx_22050612_lsu #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [4:0]        in_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd,
   output logic              out_wen,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd2;

   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        err_q, err_d;

   // Op encoding: bits [1:0] give the access size for every legal code,
   // bit 2 marks the unsigned loads and bit 3 marks stores.
   function automatic logic op_illegal(input logic [3:0] op);
      return (op == 4'd7) || (op[3] && op[2]);
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = off[0];
         2'd2:    bad = |off[1:0];
         default: bad = |off;
      endcase
      return bad;
   endfunction

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] fmt_load(input logic [1:0] size,
                                                 input logic unsigned_ld,
                                                 input logic [2:0] off,
                                                 input logic [DATA_W-1:0] rdata);
      logic [DATA_W-1:0] lane;
      logic [DATA_W-1:0] res;
      lane = rdata >> {off, 3'b000};
      case (size)
         2'd0:    res = unsigned_ld ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         2'd1:    res = unsigned_ld ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         2'd2:    res = unsigned_ld ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: res = lane;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Faulting ops skip the memory port entirely and go straight to RESP.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = in_op;
               addr_d  = in_addr;
               wdata_d = in_wdata;
               rd_d    = in_rd;
               data_d  = '0;
               if (op_illegal(in_op)) begin
                  err_d   = ERR_ILLEGAL;
                  state_d = S_RESP;
               end else if (misaligned(in_op[1:0], in_addr[2:0])) begin
                  err_d   = ERR_MISALIGN;
                  state_d = S_RESP;
               end else begin
                  err_d   = ERR_NONE;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               data_d  = op_q[3] ? '0 : fmt_load(op_q[1:0], op_q[2], addr_q[2:0], mem_rsp_rdata);
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready      = (state_q == S_IDLE);
      mem_req_valid = (state_q == S_REQ);
      mem_req_wen   = (state_q == S_REQ) && op_q[3];
      mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
      mem_req_wdata = op_q[3] ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
      mem_req_wmask = op_q[3] ? (size_mask(op_q[1:0]) << addr_q[2:0]) : 8'h00;
      out_valid     = (state_q == S_RESP);
      out_rd        = rd_q;
      out_wen       = (state_q == S_RESP) && !op_q[3] && (err_q == ERR_NONE) && (rd_q != 5'd0);
      out_data      = data_q;
      out_err       = err_q;
   end

endmodule
